// File: rtl/lenet_mac_pipe.sv
// rtl/lenet_mac_pipe.sv - pipelined multiply-accumulate with framed sums and saturated result
// Product rides NUM_STAGE registers with its beat flags; the accumulator and result register sit after the last stage.
module lenet_mac_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 32,
    parameter int NUM_STAGE = 4,
    parameter int SIGNED    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic                 acc_first,
    input  logic                 acc_last,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 overflow
);

    localparam bit IS_SIGNED = (SIGNED != 0);

    logic                 a_sx;
    logic                 b_sx;
    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] b_ext;
    logic [ACC_WIDTH-1:0] prod;

    // Operands are extended to the accumulator width first; the low ACC_WIDTH bits
    // of that product equal the full-precision product extended per SIGNED.
    assign a_sx  = IS_SIGNED & din0[A_WIDTH-1];
    assign b_sx  = IS_SIGNED & din1[B_WIDTH-1];
    assign a_ext = {{(ACC_WIDTH-A_WIDTH){a_sx}}, din0};
    assign b_ext = {{(ACC_WIDTH-B_WIDTH){b_sx}}, din1};
    assign prod  = a_ext * b_ext;

    logic [ACC_WIDTH-1:0] prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0] vld_q;
    logic [NUM_STAGE-1:0] first_q;
    logic [NUM_STAGE-1:0] last_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [OUT_WIDTH-1:0] dout_q;
    logic [OUT_WIDTH-1:0] dout_d;
    logic                 dout_valid_q;
    logic                 overflow_q;
    logic                 overflow_d;
    logic                 emit;

    always_ff @(posedge clk) begin
        if (ce) begin
            prod_q[0] <= prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
            first_q <= {first_q[NUM_STAGE-2:0], acc_first};
            last_q  <= {last_q[NUM_STAGE-2:0], acc_last};
        end
    end

    assign acc_d = first_q[NUM_STAGE-1] ? prod_q[NUM_STAGE-1]
                                        : acc_q + prod_q[NUM_STAGE-1];
    assign emit  = vld_q[NUM_STAGE-1] & last_q[NUM_STAGE-1];

    generate
        if (OUT_WIDTH < ACC_WIDTH) begin : g_sat
            logic [ACC_WIDTH-OUT_WIDTH:0]   s_head;
            logic [ACC_WIDTH-OUT_WIDTH-1:0] u_head;

            assign s_head = acc_d[ACC_WIDTH-1:OUT_WIDTH-1];
            assign u_head = acc_d[ACC_WIDTH-1:OUT_WIDTH];

            // Signed fits when every bit above the result sign bit copies it.
            always_comb begin
                dout_d     = acc_d[OUT_WIDTH-1:0];
                overflow_d = 1'b0;
                if (IS_SIGNED) begin
                    if (!(&s_head) && (|s_head)) begin
                        overflow_d = 1'b1;
                        dout_d     = acc_d[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                        : {1'b0, {(OUT_WIDTH-1){1'b1}}};
                    end
                end else if (|u_head) begin
                    overflow_d = 1'b1;
                    dout_d     = '1;
                end
            end
        end else begin : g_nosat
            assign dout_d     = acc_d[OUT_WIDTH-1:0];
            assign overflow_d = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q        <= '0;
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (ce) begin
            vld_q        <= {vld_q[NUM_STAGE-2:0], in_valid};
            dout_valid_q <= emit;
            if (vld_q[NUM_STAGE-1]) begin
                acc_q <= acc_d;
            end
            if (emit) begin
                dout_q     <= dout_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_lenet_mac_pipe.sv
// tb/tb_lenet_mac_pipe.sv - scoreboard bench driving a signed and an unsigned instance in parallel
module tb_lenet_mac_pipe;

    localparam int NSTG = 4;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [15:0] din0;
    logic [15:0] din1;
    logic        acc_first;
    logic        acc_last;
    logic [31:0] dout_s;
    logic        dv_s;
    logic        ov_s;
    logic [31:0] dout_u;
    logic        dv_u;
    logic        ov_u;

    lenet_mac_pipe #(
        .A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(32), .NUM_STAGE(NSTG), .SIGNED(1)
    ) u_s (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_first(acc_first), .acc_last(acc_last), .dout(dout_s), .dout_valid(dv_s), .overflow(ov_s)
    );

    lenet_mac_pipe #(
        .A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(32), .NUM_STAGE(NSTG), .SIGNED(0)
    ) u_u (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_first(acc_first), .acc_last(acc_last), .dout(dout_u), .dout_valid(dv_u), .overflow(ov_u)
    );

    typedef struct {
        logic [31:0] dout;
        logic        ovf;
        int          edge_n;
    } exp_t;

    exp_t   qs[$];
    exp_t   qu[$];
    longint acc_s;
    longint acc_u;
    int     checks;
    int     errors;
    int     en_cnt;
    logic   ce_e;
    logic   rst_e;
    logic [31:0] prev_d [2];
    logic        prev_v [2];
    logic        prev_o [2];

    localparam longint M40 = 64'sh100_0000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ce_e  <= ce;
        rst_e <= reset;
        if (!reset && ce) en_cnt <= en_cnt + 1;
    end

    // Reference: exact integer products, 40-bit wrapping sum, clamp to the 32-bit range.
    task automatic model_beat(input logic [15:0] a, input logic [15:0] b,
                              input logic first, input logic last, input int k);
        longint ps;
        longint pu;
        exp_t   e;
        ps = longint'($signed(a)) * longint'($signed(b));
        pu = longint'(a) * longint'(b);
        acc_s = first ? ps : acc_s + ps;
        acc_s = acc_s & (M40 - 1);
        if (acc_s >= M40 / 2) acc_s = acc_s - M40;
        acc_u = first ? pu : acc_u + pu;
        acc_u = acc_u & (M40 - 1);
        if (last) begin
            e.edge_n = k + NSTG;
            if (acc_s > 64'sd2147483647) begin
                e.dout = 32'h7FFF_FFFF; e.ovf = 1'b1;
            end else if (acc_s < -64'sd2147483648) begin
                e.dout = 32'h8000_0000; e.ovf = 1'b1;
            end else begin
                e.dout = acc_s[31:0]; e.ovf = 1'b0;
            end
            qs.push_back(e);
            if (acc_u > 64'sd4294967295) begin
                e.dout = 32'hFFFF_FFFF; e.ovf = 1'b1;
            end else begin
                e.dout = acc_u[31:0]; e.ovf = 1'b0;
            end
            qu.push_back(e);
        end
    endtask

    task automatic check_one(input int id, input logic [31:0] d, input logic v, input logic o);
        exp_t  e;
        string nm;
        int    qsz;
        nm  = (id == 0) ? "signed" : "unsigned";
        qsz = (id == 0) ? qs.size() : qu.size();
        checks++;
        if (rst_e) begin
            if (d !== 32'h0 || v !== 1'b0 || o !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%s] dout=%h valid=%b ovf=%b required 0/0/0", nm, d, v, o);
            end
        end else if (!ce_e) begin
            if (d !== prev_d[id] || v !== prev_v[id] || o !== prev_o[id]) begin
                errors++;
                $display("FAIL stall_hold[%s] dout=%h valid=%b ovf=%b required %h/%b/%b",
                         nm, d, v, o, prev_d[id], prev_v[id], prev_o[id]);
            end
        end else if (v === 1'b1) begin
            if (qsz == 0) begin
                errors++;
                $display("FAIL unexpected_result[%s] dout=%h at edge %0d required no result", nm, d, en_cnt);
            end else begin
                if (id == 0) e = qs.pop_front();
                else         e = qu.pop_front();
                if (d !== e.dout || o !== e.ovf || en_cnt != e.edge_n) begin
                    errors++;
                    $display("FAIL result[%s] dout=%h ovf=%b edge=%0d required %h/%b edge %0d",
                             nm, d, o, en_cnt, e.dout, e.ovf, e.edge_n);
                end
            end
        end else begin
            if (v !== 1'b0 || d !== prev_d[id] || o !== prev_o[id]) begin
                errors++;
                $display("FAIL idle_hold[%s] dout=%h valid=%b ovf=%b required %h/0/%b",
                         nm, d, v, o, prev_d[id], prev_o[id]);
            end
        end
        prev_d[id] = d;
        prev_v[id] = v;
        prev_o[id] = o;
    endtask

    always @(negedge clk) begin
        check_one(0, dout_s, dv_s, ov_s);
        check_one(1, dout_u, dv_u, ov_u);
    end

    task automatic cyc(input logic rst_v, input logic ce_v, input logic v, input logic first,
                       input logic last, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        #1;
        reset = rst_v; ce = ce_v; in_valid = v;
        acc_first = first; acc_last = last; din0 = a; din1 = b;
        if (rst_v) begin
            qs.delete(); qu.delete();
            acc_s = 0; acc_u = 0;
        end else if (ce_v && v) begin
            model_beat(a, b, first, last, en_cnt + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] rop();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        checks = 0; errors = 0; en_cnt = 0; acc_s = 0; acc_u = 0;
        reset = 1'b1; ce = 1'b0; in_valid = 1'b1; acc_first = 1'b1; acc_last = 1'b1;
        din0 = 16'h0011; din1 = 16'h0022;
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0033, 16'h0044);

        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd3, 16'hFFFC);
        idle(7);

        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, i == 0, i == 3, 16'd100, 16'd200);
        idle(7);

        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, i == 0, i == 3, 16'h8000, 16'h8000);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd1);
        idle(7);

        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd7, 16'd6);
        idle(1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(7);

        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd9, 16'd9);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd11, 16'd11);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd13, 16'd13);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd5, 16'd5);
        idle(7);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 16'd3);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        idle(7);

        for (int s = 0; s < 250; s++) begin
            int   len;
            logic no_first;
            len      = $urandom_range(1, 6);
            no_first = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 5) == 0) begin
                    if (rb()) cyc(1'b0, 1'b0, rb(), rb(), rb(), rop(), rop());
                    else      cyc(1'b0, 1'b1, 1'b0, rb(), rb(), rop(), rop());
                end
                cyc(1'b0, 1'b1, 1'b1, (i == 0) && !no_first, i == len - 1, rop(), rop());
            end
            if ($urandom_range(0, 59) == 0) cyc(1'b1, rb(), 1'b1, 1'b1, 1'b1, rop(), rop());
        end

        for (int i = 0; i < 40 && (qs.size() != 0 || qu.size() != 0); i++) idle(1);
        idle(2);
        checks++;
        if (qs.size() != 0 || qu.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d/%0d required 0/0", qs.size(), qu.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lenet_mac_pipe.md
LENET_MAC_PIPE -- requirements
Module: lenet_mac_pipe

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, din0 operand width.
REQ-002 SHALL have parameter B_WIDTH, default 16, din1 operand width.
REQ-003 SHALL have parameter ACC_WIDTH, default 40, internal accumulator width; legal only if ACC_WIDTH >= A_WIDTH+B_WIDTH.
REQ-004 SHALL have parameter OUT_WIDTH, default 32, result width; legal only if OUT_WIDTH <= ACC_WIDTH.
REQ-005 SHALL have parameter NUM_STAGE, default 4, multiplier pipeline depth; legal range 2..8.
REQ-006 SHALL have parameter SIGNED, default 1, 1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port ce  input  1  global clock enable; 0 freezes all state.
REQ-010 SHALL have port in_valid  input  1  din0/din1/acc_first/acc_last carry a beat.
REQ-011 SHALL have port din0  input  A_WIDTH  multiplicand.
REQ-012 SHALL have port din1  input  B_WIDTH  multiplier.
REQ-013 SHALL have port acc_first  input  1  beat starts a new sum.
REQ-014 SHALL have port acc_last  input  1  beat ends the sum; result emitted.
REQ-015 SHALL have port dout  output  OUT_WIDTH  saturated sum.
REQ-016 SHALL have port dout_valid  output  1  dout holds a new result.
REQ-017 SHALL have port overflow  output  1  saturation applied to current dout.

Function
REQ-018 A beat SHALL be accepted on a rising edge with ce=1 and in_valid=1; in_valid=0 edges insert bubbles that never touch the accumulator.
REQ-019 Product SHALL be full-precision A_WIDTH+B_WIDTH, sign- or zero-extended per SIGNED to ACC_WIDTH, carried through NUM_STAGE registers together with valid, acc_first, acc_last.
REQ-020 Accumulator update, on product valid: acc_first=1 -> acc = product; else acc = acc + product, wrapping modulo 2^ACC_WIDTH.
REQ-021 On product valid with acc_last=1, dout SHALL load the updated sum saturated to OUT_WIDTH, dout_valid=1 for exactly one ce-enabled cycle, overflow=1 iff clamping occurred.
REQ-022 Saturation range: SIGNED=1 -> [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; SIGNED=0 -> [0, 2^OUT_WIDTH-1].
REQ-023 Latency: with ce held 1, dout_valid SHALL be 1 after the (NUM_STAGE+1)-th rising edge, counting the accepting edge as edge 1.
REQ-024 Throughput: one beat per ce-enabled cycle, no back-pressure; back-to-back sums (acc_last beat followed immediately by acc_first beat) SHALL produce back-to-back results.
REQ-025 acc_first=1 and acc_last=1 on one beat SHALL emit that single product.
REQ-026 Beat with acc_first=0 after a completed sum or after reset SHALL add to current acc (0 after reset).
REQ-027 ce=0 SHALL hold every register, including dout, dout_valid, overflow; cycles with ce=0 do not count toward latency.
REQ-028 dout and overflow SHALL hold their last value while dout_valid=0.

Reset
REQ-029 reset=1 at a rising edge SHALL clear all pipeline valid bits, acc, dout, dout_valid, overflow to 0, regardless of ce.
REQ-030 Beats in flight at reset SHALL be discarded; no result from them appears afterwards.
REQ-031 Beat presented on the same edge as reset=1 SHALL be ignored.

Verification
REQ-032 Defaults, single beat din0=3, din1=-4, first=last=1 -> edge 5: dout=-12, dout_valid=1 one cycle, overflow=0.
REQ-033 Four consecutive beats 100*200, first on beat 1, last on beat 4 -> one result dout=80000, dout_valid only after edge 8.
REQ-034 Four beats (-32768)*(-32768) (sum 2^32) -> dout=0x7FFFFFFF, overflow=1; next sum 1*1 -> dout=1, overflow=0.
REQ-035 Single beat 7*6 with ce=0 for 3 cycles after edge 2 -> dout=42 appears 3 cycles late, outputs frozen during stall.
REQ-036 Two beats of a sum accepted, reset pulsed one cycle, then single beat 5*5 first=last -> only result dout=25.
REQ-037 SIGNED=0, din0=din1=0xFFFF, first=last=1 -> dout=0xFFFE0001, overflow=0.
